// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, dispatch FSM state
// encoding and bit positions inside the per-unit enable vector.
package alu_pkg;

    // ALU opcodes. Each legal opcode's value is also its enable bit index.
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRA  = 5'b00101;
    localparam logic [4:0] OP_MULT = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;

    // Dispatch FSM states. EMPTY is all-zero so reset drives the state output to 0.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_MULTI = 2'd2;

    // Bit positions in the one-hot enable vector.
    localparam int EN_ADD  = 0;
    localparam int EN_SUB  = 1;
    localparam int EN_AND  = 2;
    localparam int EN_OR   = 3;
    localparam int EN_SLL  = 4;
    localparam int EN_SRA  = 5;
    localparam int EN_MULT = 6;
    localparam int EN_DIV  = 7;
    localparam int EN_W    = 8;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> one-hot unit enable, multi-cycle
// flag and illegal flag.
// Optional feature macro: ILLEGAL_OP_TRAP_EN. When defined, unknown opcodes
// produce no enable and raise illegal; otherwise they fall back to add.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0]  opcode,
    output logic [EN_W-1:0] onehot,
    output logic            is_multi,
    output logic            illegal
);

    // Map opcode to exactly one enable bit (or none for a trapped illegal op).
    always_comb begin
        onehot   = '0;
        is_multi = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPW'(OP_ADD):  onehot[EN_ADD] = 1'b1;
            OPW'(OP_SUB):  onehot[EN_SUB] = 1'b1;
            OPW'(OP_AND):  onehot[EN_AND] = 1'b1;
            OPW'(OP_OR):   onehot[EN_OR]  = 1'b1;
            OPW'(OP_SLL):  onehot[EN_SLL] = 1'b1;
            OPW'(OP_SRA):  onehot[EN_SRA] = 1'b1;
            OPW'(OP_MULT): begin
                onehot[EN_MULT] = 1'b1;
                is_multi        = 1'b1;
            end
            OPW'(OP_DIV): begin
                onehot[EN_DIV] = 1'b1;
                is_multi       = 1'b1;
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                illegal = 1'b1;
`else
                onehot[EN_ADD] = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu_op_dispatch.sv
// Execute-stage issue register in front of the ALU units. Holds one operand
// pair with a one-hot unit enable, and stalls upstream for the fixed latency
// of mult/div.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (handled in alu_op_decode).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Upstream: accept = in_valid & in_ready; in_ready does not depend on
// in_valid. Downstream: the held entry is consumed on an edge with
// out_valid & out_ready; while out_valid=1 and out_ready=0 every registered
// output stays constant.
module alu_op_dispatch
    import alu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int OPW          = 5,
    parameter int MULTI_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_opA,
    input  logic [WIDTH-1:0] in_opB,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [4:0]       in_shamt,
    output logic [WIDTH-1:0] data_operandA,
    output logic [WIDTH-1:0] data_operandB,
    output logic [4:0]       shamt,
    output logic             add_enable,
    output logic             sub_enable,
    output logic             and_enable,
    output logic             or_enable,
    output logic             sll_enable,
    output logic             sra_enable,
    output logic             mult_enable,
    output logic             div_enable,
    output logic             multi_start,
    output logic             multi_busy,
    output logic             illegal_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       dbg_state
);

    localparam int CW = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [4:0]       shamt_q;
    logic [EN_W-1:0]  en_q;
    logic             illegal_q;
    logic             start_q;

    logic [EN_W-1:0]  dec_onehot;
    logic             dec_multi;
    logic             dec_illegal;
    logic             accept;

    alu_op_decode #(.OPW(OPW)) u_decode (
        .opcode   (in_opcode),
        .onehot   (dec_onehot),
        .is_multi (dec_multi),
        .illegal  (dec_illegal)
    );

    // Ready when empty, or when the held result leaves on this same edge.
    always_comb begin
        in_ready = (state == ST_EMPTY) || ((state == ST_HOLD) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Dispatch FSM, mult/div countdown and the issue register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            cnt       <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            shamt_q   <= '0;
            en_q      <= '0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_EMPTY, ST_HOLD: begin
                    if (accept) begin
                        opa_q     <= in_opA;
                        opb_q     <= in_opB;
                        shamt_q   <= in_shamt;
                        en_q      <= dec_onehot;
                        illegal_q <= dec_illegal;
                        if (dec_multi) begin
                            state   <= ST_MULTI;
                            cnt     <= CW'(MULTI_CYCLES - 1);
                            start_q <= 1'b1;
                        end else begin
                            state <= ST_HOLD;
                            cnt   <= '0;
                        end
                    end else if ((state == ST_HOLD) && out_ready) begin
                        // Drained: clear everything so the gated units output 0.
                        state     <= ST_EMPTY;
                        opa_q     <= '0;
                        opb_q     <= '0;
                        shamt_q   <= '0;
                        en_q      <= '0;
                        illegal_q <= 1'b0;
                    end
                end
                ST_MULTI: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_HOLD;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Fan the registered state out to the unit-facing ports.
    always_comb begin
        data_operandA = opa_q;
        data_operandB = opb_q;
        shamt         = shamt_q;
        add_enable    = en_q[EN_ADD];
        sub_enable    = en_q[EN_SUB];
        and_enable    = en_q[EN_AND];
        or_enable     = en_q[EN_OR];
        sll_enable    = en_q[EN_SLL];
        sra_enable    = en_q[EN_SRA];
        mult_enable   = en_q[EN_MULT];
        div_enable    = en_q[EN_DIV];
        multi_start   = start_q;
        multi_busy    = (state == ST_MULTI);
        illegal_op    = illegal_q;
        out_valid     = (state == ST_HOLD);
        dbg_state     = state;
    end

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Directed + random bench for alu_op_dispatch with an output scoreboard.
module tb_alu_op_dispatch;

    localparam int WIDTH = 32;
    localparam int MC    = 32;
    localparam int PW    = 2 * WIDTH + 5 + 8 + 1;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_opA;
    logic [WIDTH-1:0] in_opB;
    logic [4:0]       in_opcode;
    logic [4:0]       in_shamt;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [4:0]       shamt;
    logic             add_enable, sub_enable, and_enable, or_enable;
    logic             sll_enable, sra_enable, mult_enable, div_enable;
    logic             multi_start, multi_busy, illegal_op, out_valid, out_ready;
    logic [1:0]       dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [PW-1:0] exp_q[$];

    alu_op_dispatch #(.WIDTH(WIDTH), .OPW(5), .MULTI_CYCLES(MC)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opA(in_opA), .in_opB(in_opB), .in_opcode(in_opcode), .in_shamt(in_shamt),
        .data_operandA(data_operandA), .data_operandB(data_operandB), .shamt(shamt),
        .add_enable(add_enable), .sub_enable(sub_enable), .and_enable(and_enable),
        .or_enable(or_enable), .sll_enable(sll_enable), .sra_enable(sra_enable),
        .mult_enable(mult_enable), .div_enable(div_enable),
        .multi_start(multi_start), .multi_busy(multi_busy), .illegal_op(illegal_op),
        .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] en_obs();
        return {div_enable, mult_enable, sra_enable, sll_enable,
                or_enable, and_enable, sub_enable, add_enable};
    endfunction

    function automatic logic [PW-1:0] obs_pack();
        return {data_operandA, data_operandB, shamt, en_obs(), illegal_op};
    endfunction

    // Reference decode: opcodes 0..7 select enable bit <opcode>.
    function automatic logic [PW-1:0] exp_pack(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        logic [7:0] en;
        logic       ill;
        if (op < 5'd8) begin
            en  = 8'd1 << op;
            ill = 1'b0;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
            en  = 8'd0;
            ill = 1'b1;
`else
            en  = 8'd1;
            ill = 1'b0;
`endif
        end
        return {a, b, sh, en, ill};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_outs"}, {obs_pack(), multi_start, multi_busy, out_valid}, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // Driver: present an op, wait (bounded) for acceptance, push its expected result.
    task automatic send_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input bit rnd);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_opA    = a;
        in_opB    = b;
        in_shamt  = sh;
        for (int i = 0; i < 100 && !done; i++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) begin
                exp_q.push_back(exp_pack(op, a, b, sh));
                done = 1'b1;
            end
            step();
        end
        check("accept_within_bound", done, 1);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: each consumed result must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_output observed=%0h expected=none", obs_pack());
            end else begin
                check("scoreboard", obs_pack(), exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] ra, rb;
        logic [31:0] hold_a;

        // Reset
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opA = '0; in_opB = '0; in_opcode = '0; in_shamt = '0;
        #2;
        check_idle("reset");
        step(); step();
        reset_n = 1'b1;
        step();

        // Single-cycle OR, then drain to empty.
        out_ready = 1'b1;
        send_op(OP_OR_C(), 32'hF0F0_0000, 32'h0000_0F0F, 5'd7, 1'b0);
        idle_in();
        check("or_enable", en_obs(), 8'b0000_1000);
        check("or_opA", data_operandA, 32'hF0F0_0000);
        check("or_opB", data_operandB, 32'h0000_0F0F);
        check("or_out_valid", out_valid, 1);
        check("or_state", dbg_state, 1);
        step();
        check_idle("or_drained");

        // MULT latency: accept edge ends cycle t; now at t+1.
        send_op(5'd6, 32'd1234, 32'd5678, 5'd0, 1'b0);
        idle_in();
        check("mult_start_t1", multi_start, 1);
        check("mult_busy_t1", multi_busy, 1);
        check("mult_in_ready_t1", in_ready, 0);
        check("mult_enable_t1", en_obs(), 8'b0100_0000);
        for (int k = 2; k < MC; k++) begin
            step();
            check("mult_start_low", multi_start, 0);
            check("mult_wait", {in_ready, out_valid, mult_enable, multi_busy}, 4'b0011);
        end
        step();
        check("mult_out_valid_t32", out_valid, 1);
        check("mult_busy_t32", multi_busy, 0);
        check("mult_enable_t32", mult_enable, 1);
        check("mult_in_ready_t32", in_ready, 1);
        step();
        check_idle("mult_drained");

        // Back-to-back add then sub with no bubble.
        send_op(5'd0, 32'hAAAA_5555, 32'h1, 5'd1, 1'b0);
        check("b2b_add", en_obs(), 8'b0000_0001);
        check("b2b_in_ready", in_ready, 1);
        send_op(5'd1, 32'h0F0F_F0F0, 32'h2, 5'd2, 1'b0);
        idle_in();
        check("b2b_sub", en_obs(), 8'b0000_0010);
        check("b2b_state_hold", dbg_state, 1);
        check("b2b_in_ready_after", in_ready, 1);
        step();
        check_idle("b2b_drained");

        // Downstream stall on a held AND.
        out_ready = 1'b0;
        hold_a = 32'h1357_9BDF;
        send_op(5'd2, hold_a, 32'h2468_ACE0, 5'd9, 1'b0);
        idle_in();
        for (int k = 0; k < 5; k++) begin
            check("stall_opA", data_operandA, hold_a);
            check("stall_opB", data_operandB, 32'h2468_ACE0);
            check("stall_and", en_obs(), 8'b0000_0100);
            check("stall_flags", {in_ready, out_valid}, 2'b01);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_in_ready", in_ready, 1);
        step();
        check_idle("stall_drained");

        // Unknown opcode 01010.
        send_op(5'b01010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd3, 1'b0);
        idle_in();
`ifdef ILLEGAL_OP_TRAP_EN
        check("illegal_flag", illegal_op, 1);
        check("illegal_enables", en_obs(), 8'b0);
`else
        check("illegal_flag", illegal_op, 0);
        check("illegal_enables", en_obs(), 8'b0000_0001);
`endif
        check("illegal_out_valid", out_valid, 1);
        step();
        check_idle("illegal_drained");

        // Random ops with random downstream readiness.
        for (int n = 0; n < 24; n++) begin
            op = 5'($urandom_range(0, 11));
            ra = $urandom;
            rb = $urandom;
            send_op(op, ra, rb, 5'($urandom_range(0, 31)), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                idle_in();
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        idle_in();
        out_ready = 1'b1;
        repeat (MC + 4) step();
        check("random_queue_drained", exp_q.size(), 0);
        check_idle("random_end");

        // Reset mid-MULTI with the counter at 10.
        send_op(5'd7, 32'h55, 32'h66, 5'd4, 1'b0);
        idle_in();
        repeat (MC - 11) step();
        check("midmulti_busy", multi_busy, 1);
        reset_n = 1'b0;
        #1;
        check_idle("midmulti_reset");
        exp_q.delete();
        step();
        reset_n = 1'b1;
        step();
        check_idle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic [4:0] OP_OR_C();
        return 5'b00011;
    endfunction

endmodule
